tpu_result_reader: RTL

- Readback end of the TPU MAC output interface.
- The MAC exposes its 32-bit two's-complement accumulator as one 16-bit half at a time, selected by out_HL (0 = bits [15:0], 1 = bits [31:16]).
- This block drives out_HL, captures both halves, and reassembles the 32-bit word.
- It then re-encodes the word into the TPU 8-bit minifloat input format, so results can feed the next layer.
- Minifloat format: sign[7], exp[6:3], man[2:0]; value = (-1)^sign * {1,man} * 2^(exp-1) in accumulator units.

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/tpu_mf_encode.sv | 60 ++++++
 rtl/tpu_result_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU accumulator readback path: minifloat layout,
// accumulator widths and the reader FSM state encoding.
package tpu_pkg;

    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 3;
    localparam int MAN_W    = 3;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;

    localparam int ACC_W  = 32;
    localparam int HALF_W = 16;

    // Largest magnitude representable: {1,111} * 2^14.
    localparam logic [ACC_W-1:0] MF_MAX_MAG = 32'd245760;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL_LO,
        ST_SEL_HI,
        ST_NORM,
        ST_ENC,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/tpu_mf_encode.sv
// Magnitude+sign to 8-bit minifloat: leading-one detect, round-half-even, saturation.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
module tpu_mf_encode
    import tpu_pkg::*;
(
    input  logic [ACC_W-1:0] mag,
    input  logic             sign,
    output logic [7:0]       result,
    output logic             overflow,
    output logic             underflow
);

    logic [4:0]         lead;
    logic [MAN_W-1:0]   man;
    logic [MAN_W:0]     man_r;
    logic [5:0]         exp_v;
    logic               guard;
    logic               sticky;
    logic [ACC_W-1:0]   mask;

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        lead      = '0;
        man       = '0;
        man_r     = '0;
        exp_v     = '0;
        guard     = 1'b0;
        sticky    = 1'b0;
        mask      = '0;

        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) lead = 5'(i);
        end

        result[SIGN_BIT] = sign;
        if (mag < 32'd8) begin
            underflow = 1'b1;
        end else begin
            man = MAN_W'(mag >> (lead - 5'd3));
            // Bits below the kept mantissa only exist once the leading one is at bit 4+.
            if (lead >= 5'd4) begin
                guard  = mag[lead - 5'd4];
                mask   = (32'd1 << (lead - 5'd4)) - 32'd1;
                sticky = |(mag & mask);
            end
            man_r = {1'b0, man} + 4'(guard & (sticky | man[0]));
            exp_v = {1'b0, lead} - 6'd2 + 6'(man_r[MAN_W]);
            if (exp_v > 6'd15) begin
                overflow          = 1'b1;
                result[EXP_MSB:0] = '1;
            end else begin
                result[EXP_MSB:0] = {exp_v[EXP_W-1:0], man_r[MAN_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/tpu_result_reader.sv
// Reads the MAC accumulator as two 16-bit halves, reassembles it and encodes it to minifloat.
// Latency: 2*SETTLE_CYCLES+2 edges from accepted start to result_valid.
// Backpressure: result held in DONE until result_ready; start ignored while busy.
module tpu_result_reader
    import tpu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HALF_W-1:0] acc_half,
    output logic              out_HL,
    output logic              busy,
    output logic [ACC_W-1:0]  acc_word,
    output logic [7:0]        result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    rd_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_hl_q, out_hl_d;
    logic [ACC_W-1:0]   acc_word_q, acc_word_d;
    logic               sign_q, sign_d;
    logic [ACC_W-1:0]   mag_q, mag_d;
    logic [7:0]         result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    logic [7:0]         enc_result;
    logic               enc_ovf;
    logic               enc_udf;

    tpu_mf_encode u_enc (
        .mag       (mag_q),
        .sign      (sign_q),
        .result    (enc_result),
        .overflow  (enc_ovf),
        .underflow (enc_udf)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_word_d = acc_word_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SEL_LO;
                    cnt_d    = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    udf_d    = 1'b0;
                end
            end
            ST_SEL_LO: begin
                if (cnt_q == CNT_LAST) begin
                    acc_word_d[HALF_W-1:0] = acc_half;
                    cnt_d                  = '0;
                    state_d                = ST_SEL_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEL_HI: begin
                if (cnt_q == CNT_LAST) begin
                    acc_word_d[ACC_W-1:HALF_W] = acc_half;
                    cnt_d                      = '0;
                    state_d                    = ST_NORM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_NORM: begin
                // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
                sign_d  = acc_word_q[ACC_W-1];
                mag_d   = acc_word_q[ACC_W-1] ? (~acc_word_q + 32'd1) : acc_word_q;
                state_d = ST_ENC;
            end
            ST_ENC: begin
                result_d = enc_result;
                ovf_d    = enc_ovf;
                udf_d    = enc_udf;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        out_hl_d = (state_d == ST_SEL_HI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            out_hl_q   <= 1'b0;
            acc_word_q <= '0;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_hl_q   <= out_hl_d;
            acc_word_q <= acc_word_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign out_HL       = out_hl_q;
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign acc_word     = acc_word_q;
    assign result       = result_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
